// File: rtl/burst_arb_mux_pkg.sv
// g_arb_pkg: shared arbiter state encoding and channel-index width helper.
package g_arb_pkg;
  typedef enum logic {IDLE, LOCKED} arb_state_e;
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/burst_arb_mux_fifo2_buf.sv
// fifo2_buf: 2-entry beat buffer with push/pop, occupancy count and head view.
module fifo2_buf #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [1:0]   count_o,
  output logic [W-1:0] head_o
);
  logic [W-1:0] mem_q [2];
  logic         wp_q, rp_q;
  logic [1:0]   cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      wp_q  <= wp_q ^ push_i;
      rp_q  <= rp_q ^ pop_i;
      cnt_q <= cnt_q + 2'(push_i) - 2'(pop_i);
    end
  always_ff @(posedge clk)
    if (push_i) mem_q[wp_q] <= din_i;
  assign count_o = cnt_q;
  assign head_o  = mem_q[rp_q];
endmodule

// File: rtl/burst_arb_mux.sv
// burst_arb_mux: fixed-priority burst-locking concentrator with registered output stage.
// Define BURST_ARB_STARVE_GUARD_EN to add per-channel starvation counters that override priority in IDLE.
module burst_arb_mux import g_arb_pkg::*; #(
  parameter int Channels    = 4,
  parameter int DataWidth   = 32,
  parameter int StarveLimit = 15
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [Channels-1:0]             in_valid,
  input  logic [Channels*DataWidth-1:0]   in_data,
  input  logic [Channels-1:0]             in_last,
  output logic [Channels-1:0]             in_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DataWidth-1:0]            out_data,
  output logic                            out_last,
  output logic [$clog2(Channels)-1:0]     out_chan,
  output logic                            busy
);
  localparam int CW = chan_w(Channels);
  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic                 last;
  } beat_t;
  beat_t              head [Channels];
  logic [1:0]         cnt  [Channels];
  logic [Channels-1:0] nonempty, pop;
  arb_state_e         state_q, state_d;
  logic [CW-1:0]      lock_q, lock_d, chan_q, chan_d, pick, grant;
  logic               valid_q, valid_d, advance, pop_en;
  beat_t              beat_q, beat_d;
`ifdef BURST_ARB_STARVE_GUARD_EN
  localparam int WW = $clog2(StarveLimit + 1);
  logic [WW-1:0]       wait_q [Channels];
  logic [Channels-1:0] starving;
`else
  logic unused_starve;
  assign unused_starve = 1'(StarveLimit);
`endif
  genvar i;
  generate
    for (i = 0; i < Channels; i++) begin : g_ch
      fifo2_buf #(.W($bits(beat_t))) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (in_valid[i] & in_ready[i]),
        .pop_i   (pop[i]),
        .din_i   ({in_data[i*DataWidth +: DataWidth], in_last[i]}),
        .count_o (cnt[i]),
        .head_o  (head[i])
      );
      assign in_ready[i] = cnt[i] != 2'd2;
      assign nonempty[i] = cnt[i] != 2'd0;
`ifdef BURST_ARB_STARVE_GUARD_EN
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) wait_q[i] <= '0;
        else wait_q[i] <= pop[i] ? '0 :
                          (nonempty[i] && wait_q[i] != WW'(StarveLimit)) ? wait_q[i] + 1'b1 : wait_q[i];
      assign starving[i] = nonempty[i] && wait_q[i] == WW'(StarveLimit);
`endif
    end
  endgenerate
  // Scanning downward leaves the lowest qualifying index; starving channels scan last so they win.
  always_comb begin
    pick = '0;
    for (int c = Channels - 1; c >= 0; c--)
      if (nonempty[c]) pick = CW'(c);
`ifdef BURST_ARB_STARVE_GUARD_EN
    for (int c = Channels - 1; c >= 0; c--)
      if (starving[c]) pick = CW'(c);
`endif
  end
  assign advance = ~valid_q | out_ready;
  assign grant   = (state_q == LOCKED) ? lock_q : pick;
  assign pop_en  = advance & nonempty[grant];
  assign pop     = pop_en ? (Channels'(1) << grant) : '0;
  always_comb begin
    valid_d = advance ? pop_en : valid_q;
    beat_d  = pop_en ? head[grant] : beat_q;
    chan_d  = pop_en ? grant : chan_q;
    lock_d  = pop_en ? grant : lock_q;
    state_d = pop_en ? (head[grant].last ? IDLE : LOCKED) : state_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      lock_q  <= '0;
      valid_q <= 1'b0;
      beat_q  <= '0;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      valid_q <= valid_d;
      beat_q  <= beat_d;
      chan_q  <= chan_d;
    end
  assign out_valid = valid_q;
  assign out_data  = beat_q.data;
  assign out_last  = beat_q.last;
  assign out_chan  = chan_q;
  assign busy      = (state_q == LOCKED) | (|nonempty) | valid_q;
endmodule

// File: tb/tb_burst_arb_mux.sv
// tb_burst_arb_mux: queue-fed sources, per-channel scoreboard and burst-lock rule monitor.
module tb_burst_arb_mux;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int SL = 3;
  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    in_valid = '0;
  logic [N-1:0]    in_last = '0;
  logic [N*DW-1:0] in_data = '0;
  logic [N-1:0]    in_ready;
  logic            out_valid, out_last, busy;
  logic            out_ready = 1'b1;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_chan;
  beat_t           src_q [N][$];
  beat_t           exp_q [N][$];
  int              log_chan[$];
  int              log_cyc[$];
  int              acc_cyc [N];
  logic [N-1:0]    acc = '0;
  int              cyc = 0;
  int              tests = 0;
  int              fails = 0;
  int              lock_ch = -1;
  bit              gap_en = 0;

  burst_arb_mux #(.Channels(N), .DataWidth(DW), .StarveLimit(SL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_chan(out_chan), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input int ch, input int len, input logic [DW-1:0] base);
    for (int k = 0; k < len; k++) src_q[ch].push_back('{data: base + DW'(k), last: k == len - 1});
  endtask

  // Sources: each channel presents its queued beats in order, holding each until accepted.
  always @(posedge clk) begin
    beat_t b;
    #1;
    if (!rst_n) in_valid = '0;
    else for (int i = 0; i < N; i++) begin
      if (in_valid[i] && acc[i]) in_valid[i] = 1'b0;
      if (!in_valid[i] && src_q[i].size() != 0 && (!gap_en || $urandom_range(3) != 0)) begin
        b = src_q[i].pop_front();
        in_data[i*DW +: DW] = b.data;
        in_last[i] = b.last;
        in_valid[i] = 1'b1;
      end
    end
  end

  // Monitor: handshakes seen here complete at the following rising edge.
  always @(negedge clk) begin
    beat_t e;
    int c;
    acc = rst_n ? (in_valid & in_ready) : '0;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        c = int'(out_chan);
        chk("beat_expected", 64'(exp_q[c].size() != 0), 64'd1);
        if (exp_q[c].size() != 0) begin
          e = exp_q[c].pop_front();
          chk("out_beat", 64'({out_data, out_last}), 64'(e));
        end
        if (lock_ch >= 0) chk("no_interleave", 64'(out_chan), 64'(lock_ch));
        lock_ch = out_last ? -1 : c;
        log_chan.push_back(c);
        log_cyc.push_back(cyc);
      end
      for (int i = 0; i < N; i++)
        if (acc[i]) begin
          exp_q[i].push_back('{data: in_data[i*DW +: DW], last: in_last[i]});
          acc_cyc[i] = cyc;
        end
    end
  end

  task automatic drain(input int budget);
    int k = 0;
    int pend;
    do begin
      @(negedge clk);
      k++;
      pend = 0;
      for (int i = 0; i < N; i++) pend += src_q[i].size();
    end while ((busy || in_valid != '0 || pend != 0) && k < budget);
    @(negedge clk);
    chk("drain_in_budget", 64'(k < budget), 64'd1);
    for (int i = 0; i < N; i++) chk("scoreboard_empty", 64'(exp_q[i].size()), 64'd0);
  endtask

  initial begin
    int exp3 [5] = '{3, 3, 3, 3, 0};
    int idx;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'hF);
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_out_data", 64'(out_data), 64'd0);
    // Single beat on ch2: visible two edges after its acceptance edge.
    send(2, 1, 32'hA5);
    @(negedge clk);
    @(negedge clk);
    chk("single_not_early", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_data", 64'(out_data), 64'hA5);
    chk("single_chan", 64'(out_chan), 64'd2);
    chk("single_last", 64'(out_last), 64'd1);
    drain(50);
    chk("single_idle_busy", 64'(busy), 64'd0);
    // Ch3 burst then ch0 single one cycle later: burst must finish first.
    log_chan.delete(); log_cyc.delete();
    send(3, 4, 32'h300);
    @(negedge clk);
    send(0, 1, 32'h0F0);
    drain(100);
    chk("burst_count", 64'(log_chan.size()), 64'd5);
    for (int k = 0; k < 5; k++) if (k < log_chan.size()) chk("burst_order", 64'(log_chan[k]), 64'(exp3[k]));
    if (log_cyc.size() == 5) chk("burst_back_to_back", 64'(log_cyc[3] - log_cyc[0]), 64'd3);
    // Simultaneous singles: fixed priority, one per cycle.
    log_chan.delete(); log_cyc.delete();
    for (int i = 0; i < N; i++) send(i, 1, 32'h400 + 32'(i));
    drain(100);
    chk("simul_count", 64'(log_chan.size()), 64'd4);
    for (int k = 0; k < 4; k++) if (k < log_chan.size()) chk("simul_order", 64'(log_chan[k]), 64'(k));
    if (log_cyc.size() == 4) chk("simul_consecutive", 64'(log_cyc[3] - log_cyc[0]), 64'd3);
    // Backpressure on a ch1 stream.
    out_ready = 1'b0;
    send(1, 6, 32'h100);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_data", 64'(out_data), 64'h100);
      chk("bp_hold_last", 64'(out_last), 64'd0);
      chk("bp_in_ready1", 64'(in_ready[1]), 64'd0);
    end
    out_ready = 1'b1;
    drain(100);
    // Starvation: ch0 streams singles while ch3 holds one pending beat.
    log_chan.delete(); log_cyc.delete();
    for (int k = 0; k < 12; k++) send(0, 1, 32'h500 + 32'(k));
    repeat (3) @(negedge clk);
    send(3, 1, 32'h3A0);
    drain(200);
    idx = -1;
    for (int k = 0; k < log_chan.size(); k++) if (log_chan[k] == 3) idx = k;
    chk("starve_ch3_seen", 64'(idx >= 0), 64'd1);
`ifdef BURST_ARB_STARVE_GUARD_EN
    if (idx >= 0) chk("starve_bound", 64'((log_cyc[idx] - acc_cyc[3] - 1) <= 5), 64'd1);
`else
    chk("starve_ch3_last", 64'(idx), 64'(log_chan.size() - 1));
`endif
    // Asynchronous reset in the middle of a stalled burst.
    out_ready = 1'b0;
    send(2, 4, 32'h200);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_data", 64'(out_data), 64'd0);
    chk("arst_out_last", 64'(out_last), 64'd0);
    chk("arst_out_chan", 64'(out_chan), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'hF);
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    lock_ch = -1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);
    send(1, 2, 32'h110);
    drain(50);
    // Randomized traffic with random backpressure and source gaps.
    gap_en = 1;
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      out_ready = $urandom_range(3) != 0;
      for (int i = 0; i < N; i++)
        if (src_q[i].size() < 3 && $urandom_range(7) == 0)
          send(i, int'($urandom_range(1, 4)), {8'(i), 24'($urandom)});
    end
    out_ready = 1'b1;
    drain(3000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/burst_arb_mux.md
Name: burst_arb_mux

Overview:
- Multi-channel request concentrator placed directly downstream of the combinational priority pick.
- Each of Channels producers pushes beats through a valid/ready port into a private 2-entry buffer.
- The block grants the lowest-index non-empty buffer and locks the grant for a whole multi-beat burst (until a beat with last=1).
- Beats leave through a single registered valid/ready output stage tagged with the source channel, feeding the shared memory/execute port.

Parameters:
- Channels, 4, number of requesters; power of 2, minimum 2.
- DataWidth, 32, payload bits per beat.
- StarveLimit, 15, wait-cycle threshold; used only with the optional feature.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  Channels  per-channel beat valid.
- in_data  in  Channels*DataWidth  per-channel payload; channel i occupies bits [i*DataWidth +: DataWidth].
- in_last  in  Channels  marks the final beat of a burst.
- in_ready  out  Channels  per-channel accept.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  DataWidth  payload.
- out_last  out  1  final beat of the burst.
- out_chan  out  $clog2(Channels)  source channel index.
- busy  out  1  high when state is LOCKED or any buffer or output register is occupied.

Behaviour:
- Clock and reset: one clock (clk); asynchronous, active-low reset rst_n.
- Reset values: out_valid=0, out_data=0, out_last=0, out_chan=0, busy=0, all buffer counts=0, state=IDLE, locked channel=0. in_ready is all-ones after reset (buffers empty).
- Reset asserted mid-burst drops all buffered beats. There is no partial-burst recovery.
- Per-channel buffer: 2-entry FIFO.
  - in_ready[i] = (count[i] != 2). It is registered-count based and has no combinational path from out_ready.
  - A push occurs on in_valid[i]&in_ready[i]. Push and pop in the same cycle leave count unchanged.
- Output stage may load when ~out_valid | out_ready (advance).
- State IDLE:
  - If advance and any buffer is non-empty, grant g = lowest index with count!=0.
  - Pop head of g into the output register; set out_chan=g.
  - If head last=0, go to LOCKED with lock=g. If last=1, stay in IDLE.
- State LOCKED:
  - Only buffer lock may pop. Other channels keep buffering, but none are granted.
  - On advance with buffer lock non-empty, pop into the output register.
  - If that beat's last=1, return to IDLE.
  - If advance and buffer lock is empty, out_valid drops to 0 (a bubble). The lock holds.
- Output handshake:
  - out_* stay stable while out_valid&~out_ready.
  - When advance occurs and nothing is popped, out_valid becomes 0.
- Latency: a beat accepted at edge t appears at the output after edge t+1 at the earliest (2-cycle minimum).
- Throughput: 1 beat/cycle sustained from one channel.
- Ordering: per-channel order is preserved. Bursts from different channels never interleave on the output.
- Single-beat requests (in_last=1 on the first beat) never enter LOCKED.

Optional Feature:
- Macro: BURST_ARB_STARVE_GUARD_EN.
- Enabled:
  - Each channel has a saturating wait counter of width $clog2(StarveLimit+1).
  - The counter increments each cycle the channel's buffer is non-empty and it is not popped. It clears on pop.
  - In IDLE, the lowest-index channel whose counter == StarveLimit wins over normal priority.
  - LOCKED bursts are never preempted.
- Disabled: pure fixed priority, lowest index wins. No counters are synthesized. StarveLimit is ignored.

Decomposition:
- Package g_arb_pkg holds:
  - state enum arb_state_e {IDLE, LOCKED};
  - localparam helper for channel-index width;
  - packed beat struct {data, last}, parameterised by DataWidth via typedef in the module.
- One natural sub-module: fifo2_buf, a 2-entry buffer with push/pop/count/head. It is instantiated Channels times with a generate loop.
- Priority pick is inline combinational logic.

Test Plan:
- Reset, then idle: after rst_n rises, in_ready=4'b1111, out_valid=0, busy=0. Assert rst_n=0 asynchronously mid-burst: outputs return to 0 without waiting for a clock edge.
- Single beat on ch2 (data=0xA5, last=1), out_ready=1: out_valid=1 with out_data=0xA5, out_chan=2, out_last=1 exactly 2 cycles after acceptance. State stays IDLE.
- Ch3 sends a 4-beat burst; ch0 sends a single beat 1 cycle later: all 4 ch3 beats emerge consecutively with out_chan=3, then the ch0 beat. No interleave.
- Simultaneous single beats on ch0..ch3: outputs appear in order chan 0,1,2,3 on 4 consecutive cycles.
- Backpressure: out_ready=0 for 5 cycles while ch1 streams: out_* held stable, in_ready[1] drops after 2 buffered beats plus 1 in the output register, and no beat is lost or duplicated after out_ready=1.
- Starve test with BURST_ARB_STARVE_GUARD_EN, StarveLimit=3: ch0 continuously issues single beats and ch3 holds a pending beat. The ch3 beat is granted once its counter reaches 3 (≤ 5 cycles after it is buffered). Without the macro, ch3 waits until ch0 stops.
